// File: rtl/riscv_fetch.sv
// riscv_fetch: instruction-fetch stage feeding the IF/ID pipeline register.
// Holds the PC and a word-addressed instruction memory that is loaded through a
// dedicated write port. It honours stall and redirect requests and raises a
// sticky fetch_done once the PC walks off the end of the memory.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   stall_i               hold PC, IF/ID and fetch_done
//   redirect_valid_i      load redirect_pc_i (word aligned) and squash IF/ID
//   redirect_pc_i         redirect target, bits [1:0] ignored
//   imem_we_i/waddr/wdata instruction memory write port
//   IF_ID_pc/pc_plus4     PC of the IF/ID instruction and that PC + 4
//   IF_ID_inst/valid      fetched instruction and its valid flag
//   pc_o                  current fetch PC
//   fetch_done            sticky: PC has left the memory range
module riscv_fetch #(
  parameter int unsigned         INST_WIDTH = 32,
  parameter int unsigned         PC_WIDTH   = 32,
  parameter int unsigned         IMEM_DEPTH = 256,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          stall_i,
  input  logic                          redirect_valid_i,
  input  logic [PC_WIDTH-1:0]           redirect_pc_i,
  input  logic                          imem_we_i,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr_i,
  input  logic [INST_WIDTH-1:0]         imem_wdata_i,
  output logic [PC_WIDTH-1:0]           IF_ID_pc,
  output logic [PC_WIDTH-1:0]           IF_ID_pc_plus4,
  output logic [INST_WIDTH-1:0]         IF_ID_inst,
  output logic                          IF_ID_valid,
  output logic [PC_WIDTH-1:0]           pc_o,
  output logic                          fetch_done
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);
  localparam int unsigned IW = PC_WIDTH - 2;
  localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h0000_0013);

  logic [INST_WIDTH-1:0] mem [IMEM_DEPTH];
  logic [PC_WIDTH-1:0]   pc;
  logic [IW-1:0]         word_idx;
  logic                  in_range_c;
  logic [INST_WIDTH-1:0] rdata_c;
  logic [PC_WIDTH-1:0]   pc_plus4_c;
  logic                  unused_redirect_lsbs;

  // Word index covers every PC bit above the byte offset so that high
  // addresses are recognised as out of range rather than aliasing.
  assign word_idx   = pc[PC_WIDTH-1:2];
  assign in_range_c = 64'(word_idx) < 64'(IMEM_DEPTH);
  assign rdata_c    = mem[word_idx[AW-1:0]];
  assign pc_plus4_c = pc + PC_WIDTH'(4);
  assign pc_o       = pc;

  // Redirect targets are forced to word alignment; the low bits are dropped.
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // Write port: unaffected by reset, stall or redirect; reads see old data.
  always_ff @(posedge clk) begin
    if (imem_we_i) begin
      mem[imem_waddr_i] <= imem_wdata_i;
    end
  end

  // PC, IF/ID and fetch_done update with priority reset > redirect > stall > fetch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc             <= RESET_PC;
      IF_ID_pc       <= '0;
      IF_ID_pc_plus4 <= '0;
      IF_ID_inst     <= NOP;
      IF_ID_valid    <= 1'b0;
      fetch_done     <= 1'b0;
    end else if (redirect_valid_i) begin
      pc          <= {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
      IF_ID_inst  <= NOP;
      IF_ID_valid <= 1'b0;
      fetch_done  <= 1'b0;
    end else if (!stall_i) begin
      if (in_range_c) begin
        pc             <= pc_plus4_c;
        IF_ID_pc       <= pc;
        IF_ID_pc_plus4 <= pc_plus4_c;
        IF_ID_inst     <= rdata_c;
        IF_ID_valid    <= 1'b1;
      end else begin
        // Off the end of the program: park the PC and emit bubbles.
        IF_ID_inst  <= NOP;
        IF_ID_valid <= 1'b0;
        fetch_done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_fetch.sv
// tb_riscv_fetch: table-driven check of riscv_fetch with a 4-word memory.
module tb_riscv_fetch;

  localparam logic [31:0] I0  = 32'h0050_0093;
  localparam logic [31:0] I1  = 32'h00a0_0113;
  localparam logic [31:0] I2  = 32'h0020_81b3;
  localparam logic [31:0] I3  = 32'h0000_0013;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] NEW = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_we_i;
  logic [1:0]  imem_waddr_i;
  logic [31:0] imem_wdata_i;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_pc_plus4;
  logic [31:0] IF_ID_inst;
  logic        IF_ID_valid;
  logic [31:0] pc_o;
  logic        fetch_done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        we;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_inst;
    logic        e_valid;
    logic [31:0] e_pco;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  riscv_fetch #(
    .INST_WIDTH (32),
    .PC_WIDTH   (32),
    .IMEM_DEPTH (4),
    .RESET_PC   (32'h0)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_we_i        (imem_we_i),
    .imem_waddr_i     (imem_waddr_i),
    .imem_wdata_i     (imem_wdata_i),
    .IF_ID_pc         (IF_ID_pc),
    .IF_ID_pc_plus4   (IF_ID_pc_plus4),
    .IF_ID_inst       (IF_ID_inst),
    .IF_ID_valid      (IF_ID_valid),
    .pc_o             (pc_o),
    .fetch_done       (fetch_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                     input logic we, input logic [1:0] wa, input logic [31:0] wd,
                     input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] inst,
                     input logic v, input logic [31:0] pco, input logic d);
    vec_t t;
    t.rst_n = r;  t.stall = s;  t.rv = rv;  t.rpc = rpc;
    t.we = we;    t.wa = wa;    t.wd = wd;
    t.e_pc = pc;  t.e_pc4 = pc4; t.e_inst = inst;
    t.e_valid = v; t.e_pco = pco; t.e_done = d;
    vecs.push_back(t);
  endtask

  task automatic drive_idle(input logic r);
    reset_n = r; stall_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = '0;
    imem_we_i = 1'b0; imem_waddr_i = '0; imem_wdata_i = '0;
  endtask

  initial begin
    vec_t e;
    int   n;
    drive_idle(1'b0);

    // rst stall rv rpc        we wa wd     | pc  pc4  inst v pco  done
    add(0, 0, 0, 32'h0,  1, 2'd0, I0,  32'd0,  32'd0,  NOP, 0, 32'd0,  0); // preload in reset
    add(0, 0, 0, 32'h0,  1, 2'd1, I1,  32'd0,  32'd0,  NOP, 0, 32'd0,  0);
    add(0, 0, 0, 32'h0,  1, 2'd2, I2,  32'd0,  32'd0,  NOP, 0, 32'd0,  0);
    add(0, 0, 0, 32'h0,  1, 2'd3, I3,  32'd0,  32'd0,  NOP, 0, 32'd0,  0);
    add(1, 0, 0, 32'h0,  0, 2'd0, 0,   32'd0,  32'd4,  I0,  1, 32'd4,  0); // sequential fetch
    add(1, 0, 0, 32'h0,  0, 2'd0, 0,   32'd4,  32'd8,  I1,  1, 32'd8,  0);
    add(1, 0, 0, 32'h0,  0, 2'd0, 0,   32'd8,  32'd12, I2,  1, 32'd12, 0);
    add(1, 0, 0, 32'h0,  0, 2'd0, 0,   32'd12, 32'd16, I3,  1, 32'd16, 0);
    add(1, 0, 0, 32'h0,  0, 2'd0, 0,   32'd12, 32'd16, NOP, 0, 32'd16, 1); // end of program
    add(1, 0, 0, 32'h0,  0, 2'd0, 0,   32'd12, 32'd16, NOP, 0, 32'd16, 1);
    add(1, 0, 1, 32'h0,  0, 2'd0, 0,   32'd12, 32'd16, NOP, 0, 32'd0,  0); // redirect to 0
    add(1, 0, 0, 32'h0,  0, 2'd0, 0,   32'd0,  32'd4,  I0,  1, 32'd4,  0);
    add(1, 0, 0, 32'h0,  0, 2'd0, 0,   32'd4,  32'd8,  I1,  1, 32'd8,  0);
    add(1, 1, 0, 32'h0,  0, 2'd0, 0,   32'd4,  32'd8,  I1,  1, 32'd8,  0); // stall x2
    add(1, 1, 0, 32'h0,  0, 2'd0, 0,   32'd4,  32'd8,  I1,  1, 32'd8,  0);
    add(1, 0, 0, 32'h0,  0, 2'd0, 0,   32'd8,  32'd12, I2,  1, 32'd12, 0);
    add(1, 1, 1, 32'hE,  0, 2'd0, 0,   32'd8,  32'd12, NOP, 0, 32'hC,  0); // redirect beats stall
    add(1, 0, 0, 32'h0,  0, 2'd0, 0,   32'd12, 32'd16, I3,  1, 32'd16, 0);
    add(1, 0, 0, 32'h0,  0, 2'd0, 0,   32'd12, 32'd16, NOP, 0, 32'd16, 1);
    add(1, 1, 0, 32'h0,  0, 2'd0, 0,   32'd12, 32'd16, NOP, 0, 32'd16, 1); // stall holds done
    add(1, 0, 1, 32'h8,  0, 2'd0, 0,   32'd12, 32'd16, NOP, 0, 32'd8,  0);
    add(1, 0, 0, 32'h0,  1, 2'd2, NEW, 32'd8,  32'd12, I2,  1, 32'd12, 0); // collision: old word
    add(1, 0, 1, 32'h8,  0, 2'd0, 0,   32'd8,  32'd12, NOP, 0, 32'd8,  0);
    add(1, 0, 0, 32'h0,  0, 2'd0, 0,   32'd8,  32'd12, NEW, 1, 32'd12, 0); // new word
    add(0, 0, 0, 32'h0,  0, 2'd0, 0,   32'd0,  32'd0,  NOP, 0, 32'd0,  0); // mid-run reset
    add(1, 0, 0, 32'h0,  0, 2'd0, 0,   32'd0,  32'd4,  I0,  1, 32'd4,  0);
    add(1, 0, 0, 32'h0,  0, 2'd0, 0,   32'd4,  32'd8,  I1,  1, 32'd8,  0);
    add(1, 0, 0, 32'h0,  0, 2'd0, 0,   32'd8,  32'd12, NEW, 1, 32'd12, 0);
    add(1, 0, 0, 32'h0,  0, 2'd0, 0,   32'd12, 32'd16, I3,  1, 32'd16, 0);
    add(1, 0, 0, 32'h0,  0, 2'd0, 0,   32'd12, 32'd16, NOP, 0, 32'd16, 1);
    add(0, 0, 0, 32'h0,  0, 2'd0, 0,   32'd0,  32'd0,  NOP, 0, 32'd0,  0); // reset clears done
    add(1, 0, 1, 32'h13, 0, 2'd0, 0,   32'd0,  32'd0,  NOP, 0, 32'h10, 0); // out-of-range target
    add(1, 0, 0, 32'h0,  0, 2'd0, 0,   32'd0,  32'd0,  NOP, 0, 32'h10, 1);
    add(0, 0, 1, 32'h8,  0, 2'd0, 0,   32'd0,  32'd0,  NOP, 0, 32'd0,  0); // reset beats redirect

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset_n          = vecs[i].rst_n;
      stall_i          = vecs[i].stall;
      redirect_valid_i = vecs[i].rv;
      redirect_pc_i    = vecs[i].rpc;
      imem_we_i        = vecs[i].we;
      imem_waddr_i     = vecs[i].wa;
      imem_wdata_i     = vecs[i].wd;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("if_id_pc",    i, IF_ID_pc,       e.e_pc);
      chk("if_id_pc4",   i, IF_ID_pc_plus4, e.e_pc4);
      chk("if_id_inst",  i, IF_ID_inst,     e.e_inst);
      chk("if_id_valid", i, 32'(IF_ID_valid), 32'(e.e_valid));
      chk("pc_o",        i, pc_o,           e.e_pco);
      chk("fetch_done",  i, 32'(fetch_done), 32'(e.e_done));
    end

    // Bounded wait for fetch_done from a fresh reset: it must rise on the
    // fifth edge after release (four in-range fetches, then the first miss).
    @(negedge clk);
    drive_idle(1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (fetch_done === 1'b1) begin
        n = k;
        break;
      end
    end
    chk("done_latency", 100, 32'(n), 32'd5);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("done_sticky", 101 + k, 32'(fetch_done), 32'd1);
      chk("done_bubble", 101 + k, 32'(IF_ID_valid), 32'd0);
      chk("done_pc_hold", 101 + k, pc_o, 32'd16);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
